// File: rtl/booth_r16_pkg.sv
// Shared types and the radix-16 Booth digit decode for the multiplier controller.
package booth_r16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       neg;
        logic [3:0] mag;
    } digit_t;

    // Window is {b[i+3:i], b[i-1]}; signed digit range is -8..+8.
    function automatic digit_t booth_dec(input logic [4:0] w);
        logic signed [5:0] v;
        digit_t            d;
        v = $signed({3'b000, w[3:1]})
          + $signed({5'b00000, w[0]})
          - (w[4] ? 6'sd8 : 6'sd0);
        d.neg = v[5];
        d.mag = v[5] ? 4'(-v) : 4'(v);
        return d;
    endfunction

endpackage

// File: rtl/booth_r16_digit_dec.sv
// Combinational radix-16 Booth digit decoder.
module booth_r16_digit_dec
    import booth_r16_pkg::*;
(
    input  logic [4:0] win,
    output digit_t     dig
);

    assign dig = booth_dec(win);

endmodule

// File: rtl/booth_r16_mult_ctrl.sv
// Sequencer for a radix-16 Booth multiplier: one digit per cycle into an
// external shift register / accumulator datapath.
module booth_r16_mult_ctrl
    import booth_r16_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int NDIG  = WIDTH / 4,
    localparam int IDXW  = $clog2(NDIG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] sr_din,
    output logic             sr_shift,
    input  logic [3:0]       sr_dout,
    input  logic             sr_last,
    output logic             acc_clr,
    output logic             pp_en,
    output logic [3:0]       pp_mag,
    output logic             pp_neg,
    output logic [IDXW-1:0]  pp_idx,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t          state;
    logic [IDXW-1:0] cnt;
    digit_t          dig;
    logic            in_iter;
    logic            accept;
    logic            last_dig;

    booth_r16_digit_dec u_dec (
        .win ({sr_dout, sr_last}),
        .dig (dig)
    );

    assign in_iter  = (state == ITER);
    assign accept   = (state == IDLE) && in_valid && !flush;
    assign last_dig = (cnt == IDXW'(NDIG - 1));

    assign in_ready  = (state == IDLE);
    assign sr_shift  = in_iter;
    assign sr_din    = (state == IDLE) ? in_b : '0;
    assign acc_clr   = accept;
    assign pp_en     = in_iter && !flush;
    assign pp_mag    = in_iter ? dig.mag : 4'd0;
    assign pp_neg    = in_iter ? dig.neg : 1'b0;
    assign pp_idx    = in_iter ? cnt : '0;
    assign out_valid = (state == DONE) && !flush;

    // Counter holds on the final digit so it never wraps inside a multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) state <= ITER;
                end
                ITER: begin
                    if (last_dig) state <= DONE;
                    else          cnt   <= cnt + 1'b1;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r16_mult_ctrl.sv
// Directed bench for booth_r16_mult_ctrl with a shift register and accumulator model.
module tb_booth_r16_mult_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_b = 8'h00;
    logic [7:0] sr_din;
    logic       sr_shift;
    logic [3:0] sr_dout;
    logic       sr_last;
    logic       acc_clr;
    logic       pp_en;
    logic [3:0] pp_mag;
    logic       pp_neg;
    logic [0:0] pp_idx;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int a_op = 0;
    int acc = 0;

    logic [7:0] sr = 8'h00;
    logic       sr_lq = 1'b0;
    logic       ovr = 1'b0;
    logic [4:0] ovr_w = 5'd0;

    booth_r16_mult_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_b      (in_b),
        .sr_din    (sr_din),
        .sr_shift  (sr_shift),
        .sr_dout   (sr_dout),
        .sr_last   (sr_last),
        .acc_clr   (acc_clr),
        .pp_en     (pp_en),
        .pp_mag    (pp_mag),
        .pp_neg    (pp_neg),
        .pp_idx    (pp_idx),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    assign {sr_dout, sr_last} = ovr ? ovr_w : {sr[3:0], sr_lq};

    // External multiplier shift register: load or arithmetic shift by a nibble.
    always @(posedge clk) begin
        if (!sr_shift) begin
            sr    <= sr_din;
            sr_lq <= 1'b0;
        end else begin
            sr_lq <= sr[3];
            sr    <= {{4{sr[7]}}, sr[7:4]};
        end
    end

    function automatic int pp_term(input logic neg, input logic [3:0] mag,
                                   input logic [0:0] idx, input int a);
        int d;
        d = neg ? -int'(mag) : int'(mag);
        return (d * a) <<< (4 * int'(idx));
    endfunction

    always @(posedge clk) begin
        if (acc_clr)    acc <= 0;
        else if (pp_en) acc <= acc + pp_term(pp_neg, pp_mag, pp_idx, a_op);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep2(input logic [4:0] w0, input logic [3:0] m0,
                          input logic n0, input logic [4:0] w1,
                          input logic [3:0] m1, input logic n1);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        ovr = 1'b1;
        ovr_w = w0;
        #1;
        chk("dec_mag_a", 32'(pp_mag), 32'(m0));
        chk("dec_neg_a", 32'(pp_neg), 32'(n0));
        step();
        ovr_w = w1;
        #1;
        chk("dec_mag_b", 32'(pp_mag), 32'(m1));
        chk("dec_neg_b", 32'(pp_neg), 32'(n1));
        step();
        ovr = 1'b0;
        step();
    endtask

    task automatic run_mult(input logic [7:0] b, input int a, input int prod);
        a_op = a;
        in_b = b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        #1;
        chk("prod_valid", 32'(out_valid), 32'd1);
        chk("prod_value", 32'(acc), 32'(prod));
        step();
    endtask

    initial begin
        // Reset values
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pp_en", 32'(pp_en), 32'd0);
        chk("rst_acc_clr", 32'(acc_clr), 32'd0);
        chk("rst_sr_shift", 32'(sr_shift), 32'd0);
        #7;
        rst_n = 1'b1;

        // Handshake and latency: 0x5A * 3 = 270
        a_op = 3;
        in_b = 8'h5A;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("c0_acc_clr", 32'(acc_clr), 32'd1);
        chk("c0_in_ready", 32'(in_ready), 32'd1);
        chk("c0_pp_en", 32'(pp_en), 32'd0);
        chk("c0_sr_din", 32'(sr_din), 32'h5A);
        step();
        in_valid = 1'b0;
        #1;
        chk("c1_pp_en", 32'(pp_en), 32'd1);
        chk("c1_pp_idx", 32'(pp_idx), 32'd0);
        chk("c1_sr_shift", 32'(sr_shift), 32'd1);
        chk("c1_in_ready", 32'(in_ready), 32'd0);
        chk("c1_mag", 32'(pp_mag), 32'd6);
        chk("c1_neg", 32'(pp_neg), 32'd1);
        step();
        chk("c2_pp_en", 32'(pp_en), 32'd1);
        chk("c2_pp_idx", 32'(pp_idx), 32'd1);
        chk("c2_mag", 32'(pp_mag), 32'd6);
        chk("c2_neg", 32'(pp_neg), 32'd0);
        step();
        chk("c3_out_valid", 32'(out_valid), 32'd1);
        chk("c3_pp_en", 32'(pp_en), 32'd0);
        chk("c3_pp_mag", 32'(pp_mag), 32'd0);
        chk("c3_in_ready", 32'(in_ready), 32'd0);
        chk("c3_acc", 32'(acc), 32'd270);
        step();
        chk("c4_in_ready", 32'(in_ready), 32'd1);
        chk("c4_out_valid", 32'(out_valid), 32'd0);

        // Backpressure in DONE
        in_b = 8'h11;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_valid", 32'(out_valid), 32'd1);
        step();
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_valid", 32'(out_valid), 32'd0);

        // Flush at the first ITER cycle
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("fl_pp_en", 32'(pp_en), 32'd0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        step();
        flush = 1'b0;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_pp_en_after", 32'(pp_en), 32'd0);
        step();
        chk("fl_no_valid", 32'(out_valid), 32'd0);

        // Request coinciding with flush is discarded
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("flhs_acc_clr", 32'(acc_clr), 32'd0);
        step();
        in_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("flhs_in_ready", 32'(in_ready), 32'd1);
        chk("flhs_pp_en", 32'(pp_en), 32'd0);

        // Async reset mid-ITER
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        chk("ar_pre_pp_en", 32'(pp_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_pp_en", 32'(pp_en), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        chk("ar_sr_shift", 32'(sr_shift), 32'd0);
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        step();
        step();
        chk("ar_held_valid", 32'(out_valid), 32'd0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ar_post_valid", 32'(out_valid), 32'd0);
        end

        // First request after reset release is accepted immediately
        in_b = 8'h01;
        in_valid = 1'b1;
        #1;
        chk("ar_first_acc_clr", 32'(acc_clr), 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk("ar_first_pp_en", 32'(pp_en), 32'd1);
        step();
        step();
        step();

        // Decode sweep through the top
        sweep2(5'b00000, 4'd0, 1'b0, 5'b11111, 4'd0, 1'b0);
        sweep2(5'b10000, 4'd8, 1'b1, 5'b01111, 4'd8, 1'b0);
        sweep2(5'b00011, 4'd2, 1'b0, 5'b11100, 4'd2, 1'b1);

        // Products against a = -1
        run_mult(8'h80, -1, 128);
        run_mult(8'h7F, -1, -127);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
